// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: divider FSM states
// and redirect-source codes (the latter also feed the performance counters).
package pipe_hazard_ctrl_pkg;

  localparam int DIV_CYCLES_DEF = 33;
  localparam int CNT_W_DEF      = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef enum logic [1:0] {
    RS_NONE    = 2'd0,
    RS_COMMIT  = 2'd1,
    RS_MISPRED = 2'd2,
    RS_PEND    = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/pipe_hazard_ctrl_div_fsm.sv
// Divider occupancy FSM: holds EXE for DIV_CYCLES-1 cycles of a div/divu, then
// waits in DONE until the op can leave EXE.
module div_occupancy_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       start_i,
  input  logic       advance_i,
  output logic       div_busy_o,
  output div_state_e state_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        busy = start_i;
        if (start_i) begin
          state_d = DIV_RUN;
          cnt_d   = CNT_W'(DIV_CYCLES - 2);
        end
      end
      DIV_RUN: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        // Leave RUN when the count reaches zero so IDLE+RUN span DIV_CYCLES-1 cycles.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DIV_DONE;
          cnt_d   = '0;
        end
      end
      DIV_DONE: begin
        if (advance_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (clear_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  assign div_busy_o = busy & ~reset;
  assign state_o    = state_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: stall chain, bubble
// insertion, redirect arbitration and buffering of redirects during icache misses.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_stall,
  input  logic          id_load_use,
  input  logic          exe_div_op,
  input  logic          exe_mispredict,
  input  logic [31:0]   exe_redirect_pc,
  input  logic          mem_dcache_stall,
  input  logic          mem_exception,
  input  logic          mem_eret,
  input  logic          mem_refetch,
  input  logic [31:0]   mem_target_pc,
  output logic          pc_wr,
  output logic          id_wr,
  output logic          exe_wr,
  output logic          mem_wr,
  output logic          wb_wr,
  output logic          id_flush,
  output logic          exe_flush,
  output logic          mem_flush,
  output logic          wb_flush,
  output logic          if_kill,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          div_busy,
  output div_state_e    div_state_dbg,
  output logic          pend_dbg,
  output redirect_src_e redirect_src_dbg
);

  logic        ce, mem_st, exe_st, id_st, if_st, misp_acc, pend_block, div_busy_w;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  div_occupancy_fsm #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_div_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (ce),
    .start_i   (exe_div_op),
    .advance_i (~mem_st),
    .div_busy_o(div_busy_w),
    .state_o   (div_state_dbg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    mem_st     = mem_dcache_stall;
    exe_st     = div_busy_w | mem_st;
    id_st      = id_load_use | exe_st;
    if_st      = if_req_stall | id_st;
    ce         = mem_exception | mem_eret | mem_refetch;
    misp_acc   = exe_mispredict & ~exe_st & ~ce & ~pend_q;
    pend_block = pend_q & if_req_stall;

    id_wr            = ~id_st;
    exe_wr           = ~exe_st;
    mem_wr           = ~mem_st;
    wb_wr            = 1'b1;
    id_flush         = (if_st & ~id_st) | pend_q;
    exe_flush        = id_st & ~exe_st;
    mem_flush        = exe_st & ~mem_st;
    wb_flush         = mem_st;
    if_kill          = pend_q | misp_acc;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    redirect_src_dbg = RS_NONE;
    div_busy         = div_busy_w;

    if (ce) begin
      id_wr            = 1'b1;
      exe_wr           = 1'b1;
      mem_wr           = 1'b1;
      id_flush         = 1'b1;
      exe_flush        = 1'b1;
      mem_flush        = 1'b1;
      wb_flush         = mem_exception;
      if_kill          = 1'b1;
      redirect_valid   = 1'b1;
      redirect_pc      = mem_target_pc;
      redirect_src_dbg = RS_COMMIT;
    end else if (pend_q) begin
      redirect_valid   = 1'b1;
      redirect_pc      = pend_pc_q;
      redirect_src_dbg = RS_PEND;
    end else if (misp_acc) begin
      redirect_valid   = 1'b1;
      redirect_pc      = exe_redirect_pc;
      redirect_src_dbg = RS_MISPRED;
    end

    // A redirect loads the PC as soon as fetch is free; otherwise it is parked in pend.
    pc_wr     = redirect_valid ? ~if_req_stall : ~(if_st | pend_block);
    pend_d    = redirect_valid & if_req_stall;
    pend_pc_d = pend_d ? redirect_pc : pend_pc_q;

    if (reset) begin
      pc_wr            = 1'b0;
      id_wr            = 1'b0;
      exe_wr           = 1'b0;
      mem_wr           = 1'b0;
      wb_wr            = 1'b0;
      id_flush         = 1'b1;
      exe_flush        = 1'b1;
      mem_flush        = 1'b1;
      wb_flush         = 1'b1;
      if_kill          = 1'b1;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      redirect_src_dbg = RS_NONE;
      div_busy         = 1'b0;
    end
  end

  assign pend_dbg = pend_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the stall, divider and redirect rules.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int DC = 33;

  logic clk = 1'b0;
  logic reset, if_req_stall, id_load_use, exe_div_op, exe_mispredict;
  logic [31:0] exe_redirect_pc, mem_target_pc;
  logic mem_dcache_stall, mem_exception, mem_eret, mem_refetch;
  logic pc_wr, id_wr, exe_wr, mem_wr, wb_wr, id_flush, exe_flush, mem_flush, wb_flush;
  logic if_kill, redirect_valid, div_busy, pend_dbg;
  logic [31:0] redirect_pc;
  div_state_e div_state_dbg;
  redirect_src_e redirect_src_dbg;

  pipe_hazard_ctrl #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .if_req_stall(if_req_stall), .id_load_use(id_load_use),
    .exe_div_op(exe_div_op), .exe_mispredict(exe_mispredict), .exe_redirect_pc(exe_redirect_pc),
    .mem_dcache_stall(mem_dcache_stall), .mem_exception(mem_exception), .mem_eret(mem_eret),
    .mem_refetch(mem_refetch), .mem_target_pc(mem_target_pc), .pc_wr(pc_wr), .id_wr(id_wr),
    .exe_wr(exe_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .id_flush(id_flush), .exe_flush(exe_flush),
    .mem_flush(mem_flush), .wb_flush(wb_flush), .if_kill(if_kill), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .div_busy(div_busy), .div_state_dbg(div_state_dbg),
    .pend_dbg(pend_dbg), .redirect_src_dbg(redirect_src_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Model state: divider occupancy as "age of the op in EXE", plus the parked redirect.
  bit m_on, n_on, m_pend, n_pend;
  int m_age, n_age;
  logic [31:0] m_pend_pc, n_pend_pc;

  bit e_pc_wr, e_id_wr, e_exe_wr, e_mem_wr, e_wb_wr, e_id_flush, e_exe_flush, e_mem_flush;
  bit e_wb_flush, e_if_kill, e_rv, e_busy, e_pend;
  logic [31:0] e_rpc;
  div_state_e e_state;
  redirect_src_e e_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_req_stall = 0; id_load_use = 0; exe_div_op = 0; exe_mispredict = 0;
    exe_redirect_pc = 0; mem_dcache_stall = 0; mem_exception = 0; mem_eret = 0;
    mem_refetch = 0; mem_target_pc = 0;
  endtask

  task automatic eval_model();
    bit busy, done, mst, est, ist, fst, ce, misp;
    done = m_on && (m_age >= DC - 1);
    busy = m_on ? !done : exe_div_op;
    mst  = mem_dcache_stall;
    est  = busy || mst;
    ist  = id_load_use || est;
    fst  = if_req_stall || ist;
    ce   = mem_exception || mem_eret || mem_refetch;
    misp = exe_mispredict && !est && !ce && !m_pend;

    e_rv  = ce || m_pend || misp;
    e_rpc = ce ? mem_target_pc : m_pend ? m_pend_pc : misp ? exe_redirect_pc : 32'h0;
    e_src = ce ? RS_COMMIT : m_pend ? RS_PEND : misp ? RS_MISPRED : RS_NONE;
    e_state = !m_on ? DIV_IDLE : done ? DIV_DONE : DIV_RUN;
    e_pend  = m_pend;
    e_busy  = busy;
    e_if_kill = ce || m_pend || misp;
    if (ce) begin
      e_id_wr = 1; e_exe_wr = 1; e_mem_wr = 1; e_wb_wr = 1;
      e_id_flush = 1; e_exe_flush = 1; e_mem_flush = 1; e_wb_flush = mem_exception;
    end else begin
      e_id_wr = !ist; e_exe_wr = !est; e_mem_wr = !mst; e_wb_wr = 1;
      e_id_flush = (fst && !ist) || m_pend;
      e_exe_flush = ist && !est;
      e_mem_flush = est && !mst;
      e_wb_flush = mst;
    end
    e_pc_wr = e_rv ? !if_req_stall : (!fst && !(m_pend && if_req_stall));

    n_pend    = e_rv && if_req_stall;
    n_pend_pc = n_pend ? e_rpc : m_pend_pc;
    n_on = m_on; n_age = m_age;
    if (ce) begin
      n_on = 0; n_age = 0;
    end else if (!m_on && exe_div_op) begin
      n_on = 1; n_age = 1;
    end else if (m_on && !done) begin
      n_age = m_age + 1;
    end else if (done && !mst) begin
      n_on = 0; n_age = 0;
    end

    if (reset) begin
      e_pc_wr = 0; e_id_wr = 0; e_exe_wr = 0; e_mem_wr = 0; e_wb_wr = 0;
      e_id_flush = 1; e_exe_flush = 1; e_mem_flush = 1; e_wb_flush = 1; e_if_kill = 1;
      e_rv = 0; e_rpc = 0; e_busy = 0; e_src = RS_NONE;
      n_on = 0; n_age = 0; n_pend = 0; n_pend_pc = 0;
    end
    if (e_rv && e_pc_wr) exp_q.push_back(e_rpc);
  endtask

  task automatic compare_all();
    chk("pc_wr", 32'(pc_wr), 32'(e_pc_wr));
    chk("id_wr", 32'(id_wr), 32'(e_id_wr));
    chk("exe_wr", 32'(exe_wr), 32'(e_exe_wr));
    chk("mem_wr", 32'(mem_wr), 32'(e_mem_wr));
    chk("wb_wr", 32'(wb_wr), 32'(e_wb_wr));
    chk("id_flush", 32'(id_flush), 32'(e_id_flush));
    chk("exe_flush", 32'(exe_flush), 32'(e_exe_flush));
    chk("mem_flush", 32'(mem_flush), 32'(e_mem_flush));
    chk("wb_flush", 32'(wb_flush), 32'(e_wb_flush));
    chk("if_kill", 32'(if_kill), 32'(e_if_kill));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("div_busy", 32'(div_busy), 32'(e_busy));
    chk("div_state", 32'(div_state_dbg), 32'(e_state));
    chk("pend", 32'(pend_dbg), 32'(e_pend));
    chk("redirect_src", 32'(redirect_src_dbg), 32'(e_src));
    if (redirect_valid === 1'b1 && pc_wr === 1'b1) begin
      if (exp_q.size() == 0) chk("redirect_load_unexpected", redirect_pc, 32'hFFFF_FFFF);
      else chk("redirect_load", redirect_pc, exp_q.pop_front());
    end
  endtask

  task automatic settle_check();
    #1;
    eval_model();
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    m_on = n_on; m_age = n_age; m_pend = n_pend; m_pend_pc = n_pend_pc;
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  initial begin
    int n;
    m_on = 0; m_age = 0; m_pend = 0; m_pend_pc = 0;
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    step();

    // Load-use bubble
    id_load_use = 1;
    settle_check();
    chk("lu_exe_flush", 32'(exe_flush), 32'd1);
    chk("lu_pc_wr", 32'(pc_wr), 32'd0);
    tick();
    id_load_use = 0;
    step();

    // Divider occupancy, no MEM stall
    exe_div_op = 1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      settle_check();
      if (exe_wr === 1'b1) break;
      n++;
      tick();
    end
    chk("div_stall_cycles", 32'(n), 32'd32);
    chk("div_done_state", 32'(div_state_dbg), 32'(DIV_DONE));
    tick();
    exe_div_op = 0;
    step();

    // Divider DONE held by MEM stall, no restart
    exe_div_op = 1;
    for (int k = 0; k < 32; k++) step();
    mem_dcache_stall = 1;
    for (int k = 0; k < 3; k++) begin
      settle_check();
      chk("div_done_hold", 32'(div_state_dbg), 32'(DIV_DONE));
      tick();
    end
    mem_dcache_stall = 0;
    step();
    exe_div_op = 0;
    step();

    // Exception while div RUN and dcache stalled
    exe_div_op = 1;
    step(); step();
    exe_div_op = 0;
    mem_dcache_stall = 1;
    step();
    mem_exception = 1; mem_target_pc = 32'hBFC0_0380;
    settle_check();
    chk("exc_redirect_pc", redirect_pc, 32'hBFC0_0380);
    chk("exc_wb_flush", 32'(wb_flush), 32'd1);
    tick();
    clear_inputs();
    settle_check();
    chk("exc_div_idle", 32'(div_state_dbg), 32'(DIV_IDLE));
    tick();

    // Mispredict during icache miss
    exe_mispredict = 1; exe_redirect_pc = 32'h8000_1000; if_req_stall = 1;
    settle_check();
    chk("misp_delay_slot_kept", 32'(id_wr), 32'd1);
    tick();
    exe_mispredict = 0;
    step(); step();
    if_req_stall = 0;
    settle_check();
    chk("misp_pend_load", redirect_pc, 32'h8000_1000);
    chk("misp_pend_pc_wr", 32'(pc_wr), 32'd1);
    tick();
    step();

    // eret and mispredict together
    mem_eret = 1; mem_target_pc = 32'h8000_0200;
    exe_mispredict = 1; exe_redirect_pc = 32'h8000_4000;
    settle_check();
    chk("eret_pc", redirect_pc, 32'h8000_0200);
    chk("eret_wb_flush", 32'(wb_flush), 32'd0);
    tick();
    clear_inputs();
    settle_check();
    chk("eret_no_second", 32'(redirect_valid), 32'd0);
    tick();

    // Reset during div RUN with a parked redirect
    exe_mispredict = 1; exe_redirect_pc = 32'h8000_2000; if_req_stall = 1;
    step();
    exe_mispredict = 0; exe_div_op = 1;
    step(); step();
    reset = 1;
    settle_check();
    chk("rst_pend_before", 32'(pend_dbg), 32'd1);
    tick();
    reset = 0;
    clear_inputs();
    settle_check();
    chk("rst_div_idle", 32'(div_state_dbg), 32'(DIV_IDLE));
    chk("rst_pend_clear", 32'(pend_dbg), 32'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 299) == 0);
      if_req_stall     = ($urandom_range(0, 4) == 0);
      id_load_use      = ($urandom_range(0, 6) == 0);
      exe_div_op       = ($urandom_range(0, 19) == 0);
      exe_mispredict   = ($urandom_range(0, 9) == 0);
      exe_redirect_pc  = $urandom;
      mem_dcache_stall = ($urandom_range(0, 6) == 0);
      mem_exception    = ($urandom_range(0, 39) == 0);
      mem_eret         = ($urandom_range(0, 39) == 0);
      mem_refetch      = ($urandom_range(0, 39) == 0);
      mem_target_pc    = $urandom;
      step();
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
